// File: rtl/uart_echo_pkg.sv
// Shared types and pad map for the UART echo user design.
// Contents: RX/TX state enums, pad index constants, driven-pad mask, byte width.
package uart_echo_pkg;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    localparam int unsigned BYTE_W       = 8;

    localparam int unsigned PIN_RST      = 0;
    localparam int unsigned PIN_RX       = 1;
    localparam int unsigned PIN_TX       = 2;
    localparam int unsigned PIN_BYTE_LSB = 3;
    localparam int unsigned PIN_FULL     = 11;
    localparam int unsigned PIN_FERR     = 12;
    localparam int unsigned PIN_OVF      = 13;

    // Pads [13:2] are outputs; everything else stays an input.
    localparam int unsigned            DRIVEN_W    = 14;
    localparam logic [DRIVEN_W-1:0]    DRIVEN_MASK = 14'h3FFC;

endpackage

// File: rtl/uart_byte_fifo.sv
// Small synchronous show-ahead byte FIFO between UART RX and TX.
// Ports: clk, rst (sync, active-high), push/din write side, pop/dout read side,
//        full/empty status derived from the occupancy count.
module uart_byte_fifo
    import uart_echo_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] din,
    input  logic              pop,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    // A push into a full FIFO still lands when a pop frees the slot on the same edge.
    assign w_push_ok = push & (~full | pop);
    assign w_pop_ok  = pop & ~empty;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_user_design.sv
// UART 8N1 echo: bytes received on pad 1 are buffered and re-sent on pad 2.
// Ports: clk, rst (sync, active-high), io_in (pad inputs, [1] = rx),
//        io_out ([2] tx, [10:3] last rx byte, [11] fifo_full, [12] frame_err, [13] overflow),
//        io_oeb (constant drive enables, low on [13:2]).
module uart_echo_user_design
    import uart_echo_pkg::*;
#(
    parameter int unsigned IO_WIDTH     = 28,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IO_WIDTH-1:0] io_in,
    output logic [IO_WIDTH-1:0] io_out,
    output logic [IO_WIDTH-1:0] io_oeb
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic              r_rx_meta;
    logic              r_rx_s;
    rx_state_t         r_rx_state;
    logic [CNT_W-1:0]  r_rx_cnt;
    logic [2:0]        r_rx_bit;
    logic [BYTE_W-1:0] r_rx_shift;
    logic              r_push;
    logic [BYTE_W-1:0] r_last_byte;
    logic              r_ferr;
    logic              r_ovf;
    logic              r_full;

    tx_state_t         r_tx_state;
    logic [CNT_W-1:0]  r_tx_cnt;
    logic [2:0]        r_tx_bit;
    logic [BYTE_W-1:0] r_tx_shift;
    logic              r_tx;

    logic [BYTE_W-1:0] w_fifo_dout;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_unused;

    assign w_unused = ^{io_in[IO_WIDTH-1:PIN_RX+1], io_in[PIN_RST]};

    // Two-flop synchroniser; idles high like the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= io_in[PIN_RX];
            r_rx_s    <= r_rx_meta;
        end
    end

    // RX FSM: mid-bit sampling; pushes one cycle after a good stop sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_push      <= 1'b0;
            r_last_byte <= '0;
            r_ferr      <= 1'b0;
        end else begin
            r_push <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (!r_rx_s) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == CNT_HALF) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == CNT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s, r_rx_shift[BYTE_W-1:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == CNT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        if (r_rx_s) begin
                            r_push      <= 1'b1;
                            r_last_byte <= r_rx_shift;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // r_last_byte holds the byte being pushed while r_push is high.
    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_push),
        .din   (r_last_byte),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign w_pop = (r_tx_state == TX_IDLE) && !w_fifo_empty;

    // Sticky overflow mirrors the FIFO's drop condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_full <= w_fifo_full;
            if (r_push && w_fifo_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // TX FSM: idle state spends at least one cycle before the next start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_tx_shift <= w_fifo_dout;
                        r_tx       <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == CNT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx       <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[BYTE_W-1:1]};
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == CNT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx       <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[BYTE_W-1:1]};
                            r_tx_bit   <= r_tx_bit + 3'd1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == CNT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // Pad outputs are pure wiring of registers.
    always_comb begin
        io_out                              = '0;
        io_out[PIN_TX]                      = r_tx;
        io_out[PIN_BYTE_LSB +: BYTE_W]      = r_last_byte;
        io_out[PIN_FULL]                    = r_full;
        io_out[PIN_FERR]                    = r_ferr;
        io_out[PIN_OVF]                     = r_ovf;
    end

    assign io_oeb = ~(IO_WIDTH'(DRIVEN_MASK));

endmodule

// File: tb/tb_uart_echo_user_design.sv
// Randomized bench: drives 8N1 frames, records io_out every cycle, then compares
// each recorded cycle against a queue-based timing model of the echo path.
module tb_uart_echo_user_design;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int IOW   = 28;
    localparam int MAXC  = 32768;
    localparam int FRAME = 10 * CPB;                   // tx busy span per byte
    localparam int S_OFF = 3 + CPB / 2 + 9 * CPB;      // drive edge -> stop-sample edge

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           rx  = 1'b1;
    logic [IOW-1:0] io_in;
    logic [IOW-1:0] io_out;
    logic [IOW-1:0] io_oeb;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    logic [IOW-1:0] rec_out [MAXC];

    int          fr_e0 [$];
    logic [7:0]  fr_d  [$];
    bit          fr_ok [$];

    assign io_in = {{(IOW-2){1'b0}}, rx, rst};

    uart_echo_user_design #(
        .IO_WIDTH     (IOW),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oeb (io_oeb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [IOW-1:0] got, input logic [IOW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // io_out recorded at the falling edge following edge 'cyc'; oeb must never move.
    always @(negedge clk) begin
        if (cyc < MAXC) rec_out[cyc] = io_out;
        check("io_oeb", io_oeb, 28'hFFFC003);
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, output int ps);
        rst = 1'b1;
        ps  = cyc + 1;
        idle(n);
        rst = 1'b0;
    endtask

    // Called #1 after an edge; e0 is that edge.
    task automatic send_frame(input logic [7:0] d, input bit ok, input int stop_len);
        fr_e0.push_back(cyc);
        fr_d.push_back(d);
        fr_ok.push_back(ok);
        rx = 1'b0;
        idle(CPB);
        for (int k = 0; k < 8; k++) begin
            rx = d[k];
            idle(CPB);
        end
        if (ok) begin
            rx = 1'b1;
            idle(stop_len);
        end else begin
            rx = 1'b0;
            idle(CPB);
            rx = 1'b1;
            idle(30);
        end
    endtask

    task automatic glitch(input int low_cycles);
        rx = 1'b0;
        idle(low_cycles);
        rx = 1'b1;
        idle(30);
    endtask

    // Model: FIFO of DEPTH entries served by a transmitter that needs FRAME+1 cycles per byte.
    task automatic check_phase(input string name, input int ps, input int pe);
        int         acc_w   [$];
        int         acc_pop [$];
        logic [7:0] acc_d   [$];
        int         first_drop = MAXC;
        int         first_ferr = MAXC;
        int         last_pop   = -1000000;
        for (int i = 0; i < fr_e0.size(); i++) begin
            int s;
            int w;
            int occ;
            bit pop_now;
            s = fr_e0[i] + S_OFF;
            if (!fr_ok[i]) begin
                if (s < first_ferr) first_ferr = s;
                continue;
            end
            w       = s + 1;
            occ     = 0;
            pop_now = 1'b0;
            for (int j = 0; j < acc_pop.size(); j++) begin
                if (acc_pop[j] >= w) occ++;
                if (acc_pop[j] == w) pop_now = 1'b1;
            end
            if (occ >= DEPTH && !pop_now) begin
                if (w < first_drop) first_drop = w;
            end else begin
                int p;
                p = (w + 1 > last_pop + FRAME + 1) ? w + 1 : last_pop + FRAME + 1;
                acc_w.push_back(w);
                acc_pop.push_back(p);
                acc_d.push_back(fr_d[i]);
                last_pop = p;
            end
        end
        for (int c = ps; c <= pe; c++) begin
            logic [IOW-1:0] exp;
            logic [7:0]     lb;
            logic           tx;
            int             occ_prev;
            tx = 1'b1;
            lb = 8'h00;
            occ_prev = 0;
            for (int j = 0; j < acc_pop.size(); j++) begin
                if (c >= acc_pop[j] && c < acc_pop[j] + FRAME) begin
                    int o;
                    logic [7:0] b;
                    o = (c - acc_pop[j]) / CPB;
                    b = acc_d[j];
                    if (o == 0)      tx = 1'b0;
                    else if (o == 9) tx = 1'b1;
                    else             tx = b[o-1];
                end
                if (acc_w[j] <= c - 1 && acc_pop[j] > c - 1) occ_prev++;
            end
            for (int i = 0; i < fr_e0.size(); i++) begin
                if (fr_ok[i] && fr_e0[i] + S_OFF <= c) lb = fr_d[i];
            end
            exp        = '0;
            exp[2]     = tx;
            exp[10:3]  = lb;
            exp[11]    = (occ_prev == DEPTH);
            exp[12]    = (c >= first_ferr);
            exp[13]    = (c >= first_drop);
            check($sformatf("%s io_out @%0d", name, c), rec_out[c], exp);
        end
        fr_e0.delete();
        fr_d.delete();
        fr_ok.delete();
    endtask

    initial begin
        int ps_a;
        int ps_b;
        int ps_c;
        int pe_c;
        int ps_d;

        // Reset, single echo, glitch, framing error, then a good byte after the error.
        do_reset(3, ps_a);
        idle(5);
        send_frame(8'hA5, 1'b1, CPB);
        idle(200);
        glitch(6);
        send_frame(8'h3C, 1'b0, CPB);
        idle(200);
        send_frame(8'($urandom), 1'b1, CPB);
        idle(200);
        check_phase("rst_a5_glitch_ferr", ps_a, cyc - 1);

        // Tight stream with shortened stop bits so RX outpaces TX and the FIFO overflows.
        do_reset(2, ps_b);
        idle(3);
        for (int i = 0; i < 120; i++) begin
            logic [7:0] d;
            d = (i < 6) ? 8'(i + 1) : 8'($urandom);
            send_frame(d, 1'b1, 10);
        end
        idle(1200);
        check_phase("stream_overflow", ps_b, cyc - 1);

        // Random bytes and gaps, then 0x55 cut short by reset during data bit 4.
        do_reset(2, ps_c);
        idle(3);
        for (int i = 0; i < 6; i++) begin
            send_frame(8'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(10, 40));
        end
        idle(1000);
        send_frame(8'h55, 1'b1, CPB);
        idle(84);
        pe_c = cyc;
        do_reset(2, ps_d);
        idle(400);
        check_phase("random_then_55", ps_c, pe_c);
        check_phase("reset_mid_tx", ps_d, cyc - 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
